// File: rtl/ysyx_040750_if_fetch.sv
// Instruction fetch stage: one outstanding request, redirect handling, single-entry output hold.
// Optional macro YSYX_040750_IF_MISALIGN_CHK_EN turns a misaligned pc into a bubble instead of a request.
//
// state  | meaning
// S_IDLE | one cycle after reset, loads RESET_PC
// S_REQ  | request valid on O_inst_addr, waiting for I_inst_ready
// S_WAIT | request accepted, waiting for I_inst_rvalid
// S_HOLD | fetched instruction offered downstream
module ysyx_040750_if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        I_sys_clk,
   input  logic        I_rst,
   input  logic        I_jmp_en,
   input  logic [31:0] I_jmp_pc,
   input  logic        I_IF_ID_allowin,
   output logic        O_inst_req,
   output logic [31:0] O_inst_addr,
   input  logic        I_inst_ready,
   input  logic        I_inst_rvalid,
   input  logic [31:0] I_inst_rdata,
   output logic        O_IF_ID_valid,
   output logic [31:0] O_pc,
   output logic [31:0] O_inst,
   output logic        O_IF_ID_jmp
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] tgt, tgt_nxt;
   logic [31:0] pc_out, pc_out_nxt;
   logic [31:0] inst_out, inst_out_nxt;
   logic        flush_pend, flush_pend_nxt;
   logic        redir_pend, redir_pend_nxt;
   logic        mis_hold, mis_hold_nxt;
   logic        misaligned;

`ifdef YSYX_040750_IF_MISALIGN_CHK_EN
   assign misaligned = (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         tgt        <= 32'h0;
         pc_out     <= 32'h0;
         inst_out   <= NOP;
         flush_pend <= 1'b0;
         redir_pend <= 1'b0;
         mis_hold   <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         tgt        <= tgt_nxt;
         pc_out     <= pc_out_nxt;
         inst_out   <= inst_out_nxt;
         flush_pend <= flush_pend_nxt;
         redir_pend <= redir_pend_nxt;
         mis_hold   <= mis_hold_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      tgt_nxt        = tgt;
      pc_out_nxt     = pc_out;
      inst_out_nxt   = inst_out;
      flush_pend_nxt = flush_pend;
      redir_pend_nxt = redir_pend;
      mis_hold_nxt   = mis_hold;
      case (state)
         S_IDLE: begin
            state_nxt = S_REQ;
            pc_nxt    = RESET_PC;
         end
         S_REQ: begin
            if (misaligned) begin
               // a redirect still wins; otherwise emit a squashed bubble at this pc
               if (I_jmp_en) begin
                  pc_nxt = I_jmp_pc;
               end else begin
                  state_nxt    = S_HOLD;
                  inst_out_nxt = NOP;
                  pc_out_nxt   = pc;
                  mis_hold_nxt = 1'b1;
               end
            end else if (I_inst_ready) begin
               state_nxt = S_WAIT;
               if (I_jmp_en) begin
                  flush_pend_nxt = 1'b1;
                  tgt_nxt        = I_jmp_pc;
               end
            end else if (I_jmp_en) begin
               pc_nxt = I_jmp_pc;
            end
         end
         S_WAIT: begin
            if (I_inst_rvalid) begin
               if (flush_pend || I_jmp_en) begin
                  state_nxt      = S_REQ;
                  pc_nxt         = I_jmp_en ? I_jmp_pc : tgt;
                  flush_pend_nxt = 1'b0;
               end else begin
                  state_nxt    = S_HOLD;
                  inst_out_nxt = I_inst_rdata;
                  pc_out_nxt   = pc;
               end
            end else if (I_jmp_en) begin
               flush_pend_nxt = 1'b1;
               tgt_nxt        = I_jmp_pc;
            end
         end
         S_HOLD: begin
            if (I_IF_ID_allowin) begin
               state_nxt      = S_REQ;
               redir_pend_nxt = 1'b0;
               mis_hold_nxt   = 1'b0;
               if (I_jmp_en)        pc_nxt = I_jmp_pc;
               else if (redir_pend) pc_nxt = tgt;
               else                 pc_nxt = pc + 32'd4;
            end else if (I_jmp_en) begin
               redir_pend_nxt = 1'b1;
               tgt_nxt        = I_jmp_pc;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign O_inst_req    = (state == S_REQ) && !misaligned;
   assign O_inst_addr   = pc;
   assign O_IF_ID_valid = (state == S_HOLD);
   assign O_pc          = pc_out;
   assign O_inst        = inst_out;
   assign O_IF_ID_jmp   = (state == S_HOLD) && (redir_pend || I_jmp_en || mis_hold);

endmodule

// File: tb/tb_ysyx_040750_if_fetch.sv
// Directed bench for ysyx_040750_if_fetch: reset, fetch sequence, stall, redirects, reset abort, pc wrap.
module tb_ysyx_040750_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        jmp_en;
   logic [31:0] jmp_pc;
   logic        allowin;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        if_valid;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        if_jmp;

   int passed = 0;
   int total  = 0;

   ysyx_040750_if_fetch #(.RESET_PC(32'h8000_0000)) dut (
      .I_sys_clk       (clk),
      .I_rst           (rst),
      .I_jmp_en        (jmp_en),
      .I_jmp_pc        (jmp_pc),
      .I_IF_ID_allowin (allowin),
      .O_inst_req      (inst_req),
      .O_inst_addr     (inst_addr),
      .I_inst_ready    (inst_ready),
      .I_inst_rvalid   (rvalid),
      .I_inst_rdata    (rdata),
      .O_IF_ID_valid   (if_valid),
      .O_pc            (pc_o),
      .O_inst          (inst_o),
      .O_IF_ID_jmp     (if_jmp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // REQ at addr -> handshake -> WAIT -> zero-wait response -> HOLD
   task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
      chk({tag, "_req"}, {31'h0, inst_req}, 32'd1);
      chk({tag, "_addr"}, inst_addr, addr);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk({tag, "_wait_noreq"}, {31'h0, inst_req}, 32'd0);
      rvalid = 1'b1;
      rdata  = data;
      tick();
      rvalid = 1'b0;
      chk({tag, "_valid"}, {31'h0, if_valid}, 32'd1);
      chk({tag, "_pc"}, pc_o, addr);
      chk({tag, "_inst"}, inst_o, data);
   endtask

   task automatic do_release(input string tag);
      allowin = 1'b1;
      tick();
      allowin = 1'b0;
      chk({tag, "_drop"}, {31'h0, if_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; jmp_en = 1'b0; jmp_pc = 32'h0; allowin = 1'b0;
      inst_ready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
      tick();
      tick();
      chk("rst_req",   {31'h0, inst_req}, 32'd0);
      chk("rst_valid", {31'h0, if_valid}, 32'd0);
      chk("rst_jmp",   {31'h0, if_jmp},   32'd0);
      chk("rst_pc",    pc_o,      32'h0);
      chk("rst_inst",  inst_o,    32'h0000_0013);
      chk("rst_addr",  inst_addr, 32'h8000_0000);
      rst = 1'b0;
      #1;
      chk("idle_noreq", {31'h0, inst_req}, 32'd0);
      tick();

      // sequential fetch, 3 cycles per instruction
      do_fetch("seq0", 32'h8000_0000, 32'h0010_0093);
      do_release("seq0");
      do_fetch("seq1", 32'h8000_0004, 32'h0020_0113);
      do_release("seq1");
      do_fetch("seq2", 32'h8000_0008, 32'h0030_0193);
      do_release("seq2");
      chk("seq_next", inst_addr, 32'h8000_000C);

      // stall in HOLD, stray rvalid ignored
      reset_dut();
      do_fetch("stall", 32'h8000_0000, 32'h1111_1111);
      for (int i = 0; i < 5; i++) begin
         rvalid = (i == 2);
         rdata  = 32'hBAD0_BAD0;
         tick();
         chk("stall_valid", {31'h0, if_valid}, 32'd1);
         chk("stall_pc",    pc_o,   32'h8000_0000);
         chk("stall_inst",  inst_o, 32'h1111_1111);
      end
      rvalid = 1'b0;
      do_release("stall");
      chk("stall_next", inst_addr, 32'h8000_0004);

      // redirect during WAIT squashes the response
      reset_dut();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      jmp_en = 1'b1; jmp_pc = 32'h8000_0100;
      tick();
      jmp_en = 1'b0;
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      rvalid = 1'b0;
      chk("wflush_valid", {31'h0, if_valid}, 32'd0);
      chk("wflush_addr",  inst_addr, 32'h8000_0100);
      do_fetch("wflush_f", 32'h8000_0100, 32'h2222_2222);
      do_release("wflush_f");

      // newest redirect in WAIT wins
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      jmp_en = 1'b1; jmp_pc = 32'h8000_0500;
      tick();
      jmp_pc = 32'h8000_0600;
      tick();
      jmp_en = 1'b0;
      rvalid = 1'b1;
      tick();
      rvalid = 1'b0;
      chk("wover_addr", inst_addr, 32'h8000_0600);

      // redirect coincident with response
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      rvalid = 1'b1; jmp_en = 1'b1; jmp_pc = 32'h8000_0700;
      tick();
      rvalid = 1'b0; jmp_en = 1'b0;
      chk("wcoin_valid", {31'h0, if_valid}, 32'd0);
      chk("wcoin_addr",  inst_addr, 32'h8000_0700);

      // redirect in REQ without handshake, then with handshake
      jmp_en = 1'b1; jmp_pc = 32'h8000_0300;
      tick();
      jmp_en = 1'b0;
      chk("rjmp_req",  {31'h0, inst_req}, 32'd1);
      chk("rjmp_addr", inst_addr, 32'h8000_0300);
      inst_ready = 1'b1; jmp_en = 1'b1; jmp_pc = 32'h8000_0400;
      tick();
      inst_ready = 1'b0; jmp_en = 1'b0;
      chk("rhs_wait", {31'h0, inst_req}, 32'd0);
      rvalid = 1'b1; rdata = 32'hCAFE_0000;
      tick();
      rvalid = 1'b0;
      chk("rhs_valid", {31'h0, if_valid}, 32'd0);
      chk("rhs_addr",  inst_addr, 32'h8000_0400);

      // redirect in HOLD while stalled
      do_fetch("hjmp", 32'h8000_0400, 32'h3333_3333);
      jmp_en = 1'b1; jmp_pc = 32'h8000_0200;
      #1;
      chk("hjmp_now", {31'h0, if_jmp}, 32'd1);
      tick();
      jmp_en = 1'b0;
      #1;
      chk("hjmp_pend",  {31'h0, if_jmp}, 32'd1);
      chk("hjmp_valid", {31'h0, if_valid}, 32'd1);
      chk("hjmp_pc",    pc_o, 32'h8000_0400);
      tick();
      chk("hjmp_pend2", {31'h0, if_jmp}, 32'd1);
      allowin = 1'b1;
      tick();
      allowin = 1'b0;
      chk("hjmp_addr",  inst_addr, 32'h8000_0200);
      chk("hjmp_clear", {31'h0, if_jmp}, 32'd0);

      // pc+4 wraps modulo 2^32
      jmp_en = 1'b1; jmp_pc = 32'hFFFF_FFFC;
      tick();
      jmp_en = 1'b0;
      do_fetch("wrap", 32'hFFFF_FFFC, 32'h4444_4444);
      do_release("wrap");
      chk("wrap_addr", inst_addr, 32'h0);

      // reset mid-WAIT, late response ignored
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rvalid = 1'b1; rdata = 32'hBADB_AD00;
      tick();
      tick();
      rvalid = 1'b0;
      chk("rstw_valid", {31'h0, if_valid}, 32'd0);
      chk("rstw_inst",  inst_o, 32'h0000_0013);
      do_fetch("rstw_f", 32'h8000_0000, 32'h5555_5555);
      do_release("rstw_f");

      // misaligned target
      jmp_en = 1'b1; jmp_pc = 32'h8000_0002;
      tick();
      jmp_en = 1'b0;
`ifdef YSYX_040750_IF_MISALIGN_CHK_EN
      chk("mis_noreq", {31'h0, inst_req}, 32'd0);
      tick();
      chk("mis_valid", {31'h0, if_valid}, 32'd1);
      chk("mis_inst",  inst_o, 32'h0000_0013);
      chk("mis_pc",    pc_o,   32'h8000_0002);
      chk("mis_jmp",   {31'h0, if_jmp}, 32'd1);
      do_release("mis");
`else
      do_fetch("mis", 32'h8000_0002, 32'h6666_6666);
      chk("mis_jmp", {31'h0, if_jmp}, 32'd0);
      do_release("mis");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
